// File: rtl/dptw_axi_rd_responder_pkg.sv
// Shared encodings for the D-side page-table-walker AXI read responder:
// access-size codes, AXI field constants and the FSM state type.
`default_nettype none

package dptw_axi_rd_responder_pkg;

  localparam int DATA_TYPE__LEN = 3;

  // The low two bits of every code give log2 of the access size in bytes.
  localparam logic [DATA_TYPE__LEN-1:0] DATA_TYPE_B  = 3'd0;
  localparam logic [DATA_TYPE__LEN-1:0] DATA_TYPE_H  = 3'd1;
  localparam logic [DATA_TYPE__LEN-1:0] DATA_TYPE_W  = 3'd2;
  localparam logic [DATA_TYPE__LEN-1:0] DATA_TYPE_D  = 3'd3;
  localparam logic [DATA_TYPE__LEN-1:0] DATA_TYPE_BU = 3'd4;
  localparam logic [DATA_TYPE__LEN-1:0] DATA_TYPE_HU = 3'd5;
  localparam logic [DATA_TYPE__LEN-1:0] DATA_TYPE_WU = 3'd6;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] DPTW_AXI_PROT  = 3'b001;
  localparam logic [3:0] DPTW_AXI_CACHE = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } dptw_state_e;

  function automatic logic [1:0] size_log2(input logic [DATA_TYPE__LEN-1:0] dt);
    return dt[1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/dptw_axi_rd_responder.sv
// Single-beat uncached AXI4 read engine serving the walker's PTE reads;
// returns right-aligned, zero-extended data with a one-cycle Done pulse.
`default_nettype none

module dptw_axi_rd_responder
  import dptw_axi_rd_responder_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_M_AXI_ID         = 0
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic                          DCache_RdReq_DPTW_Valid,
  input  logic [55:0]                   DCache_RdReq_DPTW_Paddr,
  input  logic [DATA_TYPE__LEN-1:0]     DCache_RdReq_DPTW_DataType,
  output logic [63:0]                   DCache_RdResp_DPTW_Data,
  output logic                          DCache_RdResp_DPTW_Done,

  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic [3:0]                    M_AXI_ARID,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic [3:0]                    M_AXI_ARCACHE,

  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  input  logic [63:0]                   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic [3:0]                    M_AXI_RID
);

  if (C_M_AXI_DATA_WIDTH != 64) begin : g_bad_data_width
    $error("dptw_axi_rd_responder: C_M_AXI_DATA_WIDTH must be 64");
  end

  dptw_state_e               state_q, state_d;
  logic [55:0]               paddr_q, paddr_d;
  logic [DATA_TYPE__LEN-1:0] dtype_q, dtype_d;
  logic [63:0]               data_q,  data_d;

  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] sz);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

  function automatic logic [63:0] extract(input logic [63:0] rdata,
                                          input logic [2:0]  off,
                                          input logic [1:0]  sz);
    logic [63:0] shifted;
    shifted = rdata >> {off, 3'b000};
    case (sz)
      2'd0:    return {56'd0, shifted[7:0]};
      2'd1:    return {48'd0, shifted[15:0]};
      2'd2:    return {32'd0, shifted[31:0]};
      default: return shifted;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      paddr_q <= '0;
      dtype_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      paddr_q <= paddr_d;
      dtype_q <= dtype_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    paddr_d = paddr_q;
    dtype_d = dtype_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (DCache_RdReq_DPTW_Valid) begin
          paddr_d = DCache_RdReq_DPTW_Paddr;
          dtype_d = DCache_RdReq_DPTW_DataType;
          // Misaligned requests never reach the bus; the walker sees a zero PTE.
          if (misaligned(DCache_RdReq_DPTW_Paddr[2:0], size_log2(DCache_RdReq_DPTW_DataType))) begin
            data_d  = '0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_AR;
          end
        end
      end
      ST_AR: begin
        if (M_AXI_ARREADY) state_d = ST_R;
      end
      ST_R: begin
        if (M_AXI_RVALID) begin
          data_d  = (M_AXI_RRESP == AXI_RESP_OKAY)
                  ? extract(M_AXI_RDATA, paddr_q[2:0], size_log2(dtype_q))
                  : 64'd0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign M_AXI_ARVALID           = (state_q == ST_AR);
  assign M_AXI_RREADY            = (state_q == ST_R);
  assign DCache_RdResp_DPTW_Done = (state_q == ST_DONE);
  assign DCache_RdResp_DPTW_Data = data_q;

  if (C_M_AXI_ADDR_WIDTH > 56) begin : g_addr_ext
    assign M_AXI_ARADDR = {{(C_M_AXI_ADDR_WIDTH-56){1'b0}}, paddr_q};
  end else if (C_M_AXI_ADDR_WIDTH == 56) begin : g_addr_exact
    assign M_AXI_ARADDR = paddr_q;
  end else begin : g_addr_bad
    $error("dptw_axi_rd_responder: C_M_AXI_ADDR_WIDTH must be >= 56");
    assign M_AXI_ARADDR = '0;
  end

  assign M_AXI_ARSIZE  = {1'b0, size_log2(dtype_q)};
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARID    = 4'(C_M_AXI_ID);
  assign M_AXI_ARPROT  = DPTW_AXI_PROT;
  assign M_AXI_ARCACHE = DPTW_AXI_CACHE;

  // Single-beat reads make RLAST redundant and RID is never routed back here.
  logic unused_inputs;
  assign unused_inputs = ^{M_AXI_RLAST, M_AXI_RID, dtype_q[DATA_TYPE__LEN-1]};

endmodule

`default_nettype wire

// File: tb/tb_dptw_axi_rd_responder.sv
// Directed plus randomized bench for dptw_axi_rd_responder, acting as
// both walker requester and AXI slave, checked against a byte-level model.
`default_nettype none

module tb_dptw_axi_rd_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [55:0] req_paddr;
  logic [2:0]  req_dtype;
  logic [63:0] resp_data;
  logic        resp_done;
  logic        arvalid, arready;
  logic [63:0] araddr;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic [2:0]  arprot;
  logic [3:0]  arcache;
  logic        rvalid, rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dptw_axi_rd_responder dut (
    .clk                        (clk),
    .rst                        (rst),
    .DCache_RdReq_DPTW_Valid    (req_valid),
    .DCache_RdReq_DPTW_Paddr    (req_paddr),
    .DCache_RdReq_DPTW_DataType (req_dtype),
    .DCache_RdResp_DPTW_Data    (resp_data),
    .DCache_RdResp_DPTW_Done    (resp_done),
    .M_AXI_ARVALID              (arvalid),
    .M_AXI_ARREADY              (arready),
    .M_AXI_ARADDR               (araddr),
    .M_AXI_ARSIZE               (arsize),
    .M_AXI_ARLEN                (arlen),
    .M_AXI_ARBURST              (arburst),
    .M_AXI_ARID                 (arid),
    .M_AXI_ARPROT               (arprot),
    .M_AXI_ARCACHE              (arcache),
    .M_AXI_RVALID               (rvalid),
    .M_AXI_RREADY               (rready),
    .M_AXI_RDATA                (rdata),
    .M_AXI_RRESP                (rresp),
    .M_AXI_RLAST                (rlast),
    .M_AXI_RID                  (rid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Reference: bytes [off, off+n) of the beat, right-aligned; zero on misalignment or error.
  function automatic logic [63:0] ref_data(input logic [55:0] pa, input logic [2:0] dt,
                                           input logic [63:0] beat, input logic [1:0] resp);
    int nb;
    int off;
    logic [63:0] r;
    nb  = 1 << dt[1:0];
    off = int'(pa[2:0]);
    r   = '0;
    if ((off % nb) != 0 || resp != 2'b00) return 64'd0;
    for (int i = 0; i < nb; i++) r[i*8 +: 8] = beat[(off+i)*8 +: 8];
    return r;
  endfunction

  task automatic run_req(input string tag, input logic [55:0] pa, input logic [2:0] dt,
                         input int ard, input int rd, input logic [63:0] beat,
                         input logic [1:0] resp);
    int          c, done_cnt, done_at, ar_hs, ar_wait, r_wait, nb, exp_done;
    bit          ar_seen, stable, mis;
    logic [63:0] addr0, dat, exp_data;
    logic [23:0] arf;
    nb       = 1 << dt[1:0];
    mis      = (int'(pa[2:0]) % nb) != 0;
    exp_data = ref_data(pa, dt, beat, resp);
    exp_done = mis ? 1 : 3 + ard + rd;
    c = 0; done_cnt = 0; done_at = -1; ar_hs = 0; ar_wait = 0; r_wait = 0;
    ar_seen = 0; stable = 1; addr0 = '0; dat = '0; arf = '0;

    @(posedge clk); #1;
    req_valid = 1'b1; req_paddr = pa; req_dtype = dt;
    while (c < 60 && !(done_cnt > 0 && c >= done_at + 2)) begin
      @(posedge clk); #1;
      c++;
      if (resp_done) begin
        done_cnt++; done_at = c; dat = resp_data; req_valid = 1'b0;
      end
      if (arvalid) begin
        if (!ar_seen) begin addr0 = araddr; ar_seen = 1; end
        else if (araddr !== addr0) stable = 0;
        arready = (ar_wait == ard);
        ar_wait++;
        if (arready) begin
          ar_hs++;
          arf = {arsize, arlen, arburst, arid, arprot, arcache};
        end
      end else begin
        arready = 1'b0;
      end
      if (rready) begin
        rvalid = (r_wait == rd);
        r_wait++;
        rdata  = rvalid ? beat : {$urandom, $urandom};
        rresp  = resp;
      end else begin
        rvalid = 1'b0;
      end
    end
    arready = 1'b0; rvalid = 1'b0; req_valid = 1'b0;

    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_done_cycle"},  64'(done_at),  64'(exp_done));
    chk({tag, "_data"},        dat,           exp_data);
    chk({tag, "_ar_handshakes"}, 64'(ar_hs),  mis ? 64'd0 : 64'd1);
    if (!mis) begin
      chk({tag, "_araddr"},    addr0,         {8'd0, pa});
      chk({tag, "_ar_stable"}, 64'(stable),   64'd1);
      chk({tag, "_ar_fields"}, 64'(arf),
          64'({1'b0, dt[1:0], 8'h00, 2'b01, 4'h0, 3'b001, 4'b0000}));
    end
  endtask

  initial begin
    logic [55:0] pa;
    logic [2:0]  dt;
    logic [1:0]  rs;

    rst = 1'b1; req_valid = 1'b0; req_paddr = '0; req_dtype = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b1; rid = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_arvalid", 64'(arvalid),   64'd0);
    chk("reset_rready",  64'(rready),    64'd0);
    chk("reset_done",    64'(resp_done), 64'd0);
    chk("reset_data",    resp_data,      64'd0);
    chk("reset_araddr",  araddr,         64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_req("d_aligned",  56'h0000_8000_1000, 3'd3, 0, 0, 64'h0000_0002_0000_0C01, 2'b00);
    run_req("w_upper",    56'h0000_8000_1004, 3'd2, 0, 0, 64'hDEAD_BEEF_1234_5678, 2'b00);
    run_req("d_misalign", 56'h0000_8000_1003, 3'd3, 0, 0, 64'h1111_2222_3333_4444, 2'b00);
    run_req("stalls",     56'h0000_8000_2008, 3'd3, 5, 3, 64'hCAFE_F00D_0BAD_BEEF, 2'b00);
    run_req("slverr",     56'h0000_8000_3000, 3'd3, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10);
    run_req("b_off7",     56'h00AB_CDEF_0007, 3'd4, 0, 1, 64'h8877_6655_4433_2211, 2'b00);
    run_req("h_off6",     56'h0012_3456_7896, 3'd1, 2, 0, 64'h8877_6655_4433_2211, 2'b00);

    // Reset while waiting for the R beat.
    @(posedge clk); #1;
    req_valid = 1'b1; req_paddr = 56'h0000_8000_4000; req_dtype = 3'd3;
    @(posedge clk); #1;
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    chk("midrst_in_r", 64'(rready), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_arvalid", 64'(arvalid),   64'd0);
    chk("midrst_rready",  64'(rready),    64'd0);
    chk("midrst_done",    64'(resp_done), 64'd0);
    chk("midrst_data",    resp_data,      64'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_req("after_rst", 56'h0000_8000_5010, 3'd2, 0, 2, 64'h0102_0304_A5A5_5A5A, 2'b00);

    for (int i = 0; i < 16; i++) begin
      dt = 3'($urandom_range(0, 6));
      pa = {$urandom, $urandom};
      rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_req($sformatf("rand%0d", i), pa, dt, $urandom_range(0, 3), $urandom_range(0, 3),
              {$urandom, $urandom}, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
